fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage_branch_target_calc.sv | 19 +
 rtl/fetch_stage.sv | 75 +++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, PC-select enum and branch-offset helper for the LEGv8 fetch stage.
package fetch_pkg;

    localparam int unsigned    MAX_ADDR_W = 64;
    localparam logic [31:0]    NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned    PC_STEP    = 4;
    localparam int unsigned    OFF26_W    = 26;
    localparam int unsigned    OFF19_W    = 19;
    localparam int unsigned    OFF_SHIFT  = 2;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_HOLD   = 2'd1,
        PC_SEL_BRANCH = 2'd2
    } pc_sel_e;

    // Word offset -> sign-extended byte offset (B uses 26 bits, B.cond/CBZ use 19).
    function automatic logic [MAX_ADDR_W-1:0] sext_offset(
        input logic               uncond,
        input logic [OFF26_W-1:0] addr26,
        input logic [OFF19_W-1:0] addr19
    );
        logic [MAX_ADDR_W-1:0] w_word_off;
        if (uncond)
            w_word_off = {{(MAX_ADDR_W-OFF26_W){addr26[OFF26_W-1]}}, addr26};
        else
            w_word_off = {{(MAX_ADDR_W-OFF19_W){addr19[OFF19_W-1]}}, addr19};
        return w_word_off << OFF_SHIFT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard/branch controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
);
    logic                stall;
    logic                br_taken;
    logic                uncond_br;
    logic [OFF26_W-1:0]  br_addr26;
    logic [OFF19_W-1:0]  cond_addr19;
    logic [ADDR_W-1:0]   br_pc;
    logic [ADDR_W-1:0]   imem_addr;
    logic [31:0]         imem_data;
    logic [31:0]         if_id_instr;
    logic [ADDR_W-1:0]   if_id_pc;
    logic                if_id_valid;

    // Pipeline control / instruction memory side.
    modport master (
        output stall, br_taken, uncond_br, br_addr26, cond_addr19, br_pc, imem_data,
        input  imem_addr, if_id_instr, if_id_pc, if_id_valid
    );

    // Fetch stage side.
    modport slave (
        input  stall, br_taken, uncond_br, br_addr26, cond_addr19, br_pc, imem_data,
        output imem_addr, if_id_instr, if_id_pc, if_id_valid
    );
endinterface

// File: rtl/fetch_stage_branch_target_calc.sv
// Combinational branch target: br_pc + (sign-extended word offset << 2), wrapping.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  i_br_pc,
    input  logic               i_uncond_br,
    input  logic [OFF26_W-1:0] i_br_addr26,
    input  logic [OFF19_W-1:0] i_cond_addr19,
    output logic [ADDR_W-1:0]  o_target
);

    logic [MAX_ADDR_W-1:0] w_offset;

    assign w_offset = sext_offset(i_uncond_br, i_br_addr26, i_cond_addr19);
    assign o_target = i_br_pc + w_offset[ADDR_W-1:0];

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC register, async imem address, IF/ID register with flush/stall.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_if_id_instr;
    logic [ADDR_W-1:0] r_if_id_pc;
    logic              r_if_id_valid;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_seq;
    pc_sel_e           w_sel;

    branch_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target (
        .i_br_pc       (bus.br_pc),
        .i_uncond_br   (bus.uncond_br),
        .i_br_addr26   (bus.br_addr26),
        .i_cond_addr19 (bus.cond_addr19),
        .o_target      (w_target)
    );

    assign w_pc_seq = r_pc + ADDR_W'(PC_STEP);

    // A taken branch outranks a stall: the wrong-path word must be squashed regardless.
    always_comb begin
        w_sel = PC_SEL_SEQ;
        if (bus.br_taken)
            w_sel = PC_SEL_BRANCH;
        else if (bus.stall)
            w_sel = PC_SEL_HOLD;
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            case (w_sel)
                PC_SEL_BRANCH: begin
                    r_pc          <= w_target;
                    r_if_id_instr <= NOP_INSTR;
                    r_if_id_pc    <= '0;
                    r_if_id_valid <= 1'b0;
                end
                PC_SEL_SEQ: begin
                    r_pc          <= w_pc_seq;
                    r_if_id_instr <= bus.imem_data;
                    r_if_id_pc    <= r_pc;
                    r_if_id_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed branch/stall/wrap cases plus random traffic.
module tb_fetch_stage;

    logic clk;
    logic reset;

    fetch_stage_if #(.ADDR_W(64)) bus();

    fetch_stage #(
        .ADDR_W   (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] ifpc;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_ifpc;
    logic        m_valid;

    // Instruction memory contents: fixed words at 0/4/8, hashed elsewhere.
    function automatic logic [31:0] imem_word(input logic [63:0] addr);
        logic [63:0] h;
        case (addr)
            64'h0:   return 32'h9100_0421;
            64'h4:   return 32'hAB02_0020;
            64'h8:   return 32'hCB03_0040;
            default: begin
                h = (addr ^ 64'h5A5A_1234_0F0F_9876) * 64'h9E37_79B9_7F4A_7C15;
                return h[44:13];
            end
        endcase
    endfunction

    assign bus.imem_data = imem_word(bus.imem_addr);

    function automatic logic [63:0] ref_target(input bit u, input logic [25:0] a26,
                                               input logic [18:0] a19, input logic [63:0] bpc);
        longint off;
        if (u) off = longint'($signed(a26));
        else   off = longint'($signed(a19));
        return bpc + 64'(off * 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".imem_addr"}, bus.imem_addr, 64'h0);
        check({tag, ".instr"}, 64'(bus.if_id_instr), 64'h0);
        check({tag, ".ifpc"}, bus.if_id_pc, 64'h0);
        check({tag, ".valid"}, 64'(bus.if_id_valid), 64'h0);
    endtask

    task automatic model_reset();
        m_pc    = 64'h0;
        m_instr = 32'h0;
        m_ifpc  = 64'h0;
        m_valid = 1'b0;
    endtask

    // Drive one cycle of inputs, let the edge happen, and post the expected state.
    task automatic step(input bit s, input bit b, input bit u, input logic [25:0] a26,
                        input logic [18:0] a19, input logic [63:0] bpc);
        exp_t e;
        bus.stall       = s;
        bus.br_taken    = b;
        bus.uncond_br   = u;
        bus.br_addr26   = a26;
        bus.cond_addr19 = a19;
        bus.br_pc       = bpc;
        if (b) begin
            e.pc = ref_target(u, a26, a19, bpc);
            e.instr = 32'h0; e.ifpc = 64'h0; e.valid = 1'b0;
        end else if (s) begin
            e.pc = m_pc; e.instr = m_instr; e.ifpc = m_ifpc; e.valid = m_valid;
        end else begin
            e.instr = imem_word(m_pc); e.ifpc = m_pc; e.valid = 1'b1;
            e.pc = m_pc + 64'd4;
        end
        @(posedge clk);
        #1;
        m_pc = e.pc; m_instr = e.instr; m_ifpc = e.ifpc; m_valid = e.valid;
        exp_q.push_back(e);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 26'h0, 19'h0, 64'h0);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_addr", bus.imem_addr, e.pc);
                check("if_id_instr", 64'(bus.if_id_instr), 64'(e.instr));
                check("if_id_pc", bus.if_id_pc, e.ifpc);
                check("if_id_valid", 64'(bus.if_id_valid), 64'(e.valid));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0; bus.br_taken = 1'b0; bus.uncond_br = 1'b0;
        bus.br_addr26 = '0; bus.cond_addr19 = '0; bus.br_pc = '0;
        model_reset();
        #1;
        check_reset("por");
        repeat (2) @(posedge clk);
        #1;
        check_reset("por_held");
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Free run from reset: words at 0, 4, 8; imem_addr ends at 12.
        run(3);

        // B with offset -2 from 0x40, then the target word arrives after one bubble.
        step(0, 1, 1, 26'h3FF_FFFE, 19'h0, 64'h40);
        run(1);

        // CBZ forward and backward (wraps below zero).
        step(0, 1, 0, 26'h0, 19'h0_0005, 64'h100);
        run(1);
        step(0, 1, 0, 26'h0, 19'h7_FFFC, 64'h8);
        run(2);

        // PC at 0x20 with a valid word in IF/ID, then stall for three edges.
        step(0, 1, 0, 26'h0, 19'h0_0005, 64'h8);
        run(1);
        repeat (3) step(1, 0, 0, 26'h0, 19'h0, 64'h0);

        // Stall and branch together: branch wins, IF/ID flushed.
        step(1, 1, 1, 26'h000_0010, 19'h0, 64'h200);
        run(1);

        // Wrap of the sequential PC from all-ones-minus-3 to 0.
        step(0, 1, 1, 26'h3FF_FFFF, 19'h0, 64'h0);
        run(2);

        // br_taken held for two edges with different inputs each edge.
        step(0, 1, 1, 26'h000_0100, 19'h0, 64'h1000);
        step(0, 1, 0, 26'h0, 19'h0_0040, 64'h3000);
        run(2);

        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
                 26'($urandom), 19'($urandom), {$urandom, $urandom});

        // Asynchronous reset between edges, mid-stall and mid-redirect inputs applied.
        bus.stall = 1'b1; bus.br_taken = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("reset_over_edge");
        @(negedge clk);
        #1;
        reset = 1'b0;
        run(3);

        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
                 26'($urandom), 19'($urandom), {32'h0, $urandom});

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
